// File: rtl/qspi_pkg.sv
// Shared constants and FSM encoding for the QSPI-to-RAM bridge.
package qspi_pkg;

  localparam logic [7:0] CMD_QWRITE       = 8'h38;
  localparam logic [7:0] CMD_QREAD        = 8'hEB;
  localparam int         RD_DUMMY_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    DUMMY,
    RDATA,
    IGNORE
  } state_t;

endpackage

// File: rtl/qspi_ram_bridge_if.sv
// Byte-wide RAM port shared by the bridge (master) and the operand/result RAM (slave).
interface qspi_ram_bridge_if #(
  parameter int addr_width = 8
);
  // Strobe semantics, no backpressure: ram_wen/ram_ren are single-clk strobes qualified by ram_addr
  // in the same clk; ram_rdata is valid the clk after ram_ren. wen and ren are never high together.
  logic [addr_width-1:0] ram_addr;
  logic [7:0]            ram_wdata;
  logic                  ram_wen;
  logic                  ram_ren;
  logic [7:0]            ram_rdata;

  modport master (
    output ram_addr, ram_wdata, ram_wen, ram_ren,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_wen, ram_ren,
    output ram_rdata
  );
endinterface

// File: rtl/qspi_edge_sync.sv
// Two-flop synchronisers for the QSPI pins plus edge detect on synchronised sclk and cs_n.
module qspi_edge_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic [3:0] sio,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_rise,
  output logic       cs_fall,
  output logic [3:0] sio_s
);

  logic       sclk_m, sclk_s, sclk_d;
  logic       cs_m, cs_s, cs_d;
  logic [3:0] sio_m;

  // cs_n flops reset low so a host still holding cs_n low after reset cannot look like a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      cs_m   <= 1'b0;
      cs_s   <= 1'b0;
      cs_d   <= 1'b0;
      sio_m  <= 4'h0;
      sio_s  <= 4'h0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      cs_m   <= cs_n;
      cs_s   <= cs_m;
      cs_d   <= cs_s;
      sio_m  <= sio;
      sio_s  <= sio_m;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

endmodule

// File: rtl/qspi_ram_bridge.sv
// Quad-SPI slave that turns host write/read frames into byte accesses on the operand/result RAM.
module qspi_ram_bridge
  import qspi_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int RD_DUMMY   = RD_DUMMY_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                qspi_sclk,
  input  logic                qspi_cs_n,
  input  logic [3:0]          qspi_sio_in,
  output logic [3:0]          qspi_sio_out,
  output logic                qspi_sio_oe,
  qspi_ram_bridge_if.master   ram,
  output logic                frame_done,
  output state_t              fsm_state
);

  localparam logic [3:0] DUMMY_LAST = 4'(RD_DUMMY - 1);

  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [3:0] sio_s;

  qspi_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (qspi_sclk),
    .cs_n      (qspi_cs_n),
    .sio       (qspi_sio_in),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .sio_s     (sio_s)
  );

  state_t                state_q, state_d;
  logic                  nib_q;
  logic [3:0]            rx_hi_q;
  logic [3:0]            dcnt_q;
  logic                  is_write_q, wrote_q;
  logic [addr_width-1:0] addr_q;
  logic [7:0]            wdata_q, rd_buf_q;
  logic [3:0]            tx_lo_q, sio_out_q;
  logic                  wen_q, ren_q, load_q, oe_q, done_q;
  logic [7:0]            rx_byte;
  logic                  byte_done;

  assign rx_byte   = {rx_hi_q, sio_s};
  assign byte_done = !cs_rise && sclk_rise && nib_q &&
                     (state_q == CMD || state_q == ADDR || state_q == WDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (cs_fall) state_d = CMD;
        CMD:   if (byte_done)
                 state_d = (rx_byte == CMD_QWRITE || rx_byte == CMD_QREAD) ? ADDR : IGNORE;
        ADDR:  if (byte_done) state_d = is_write_q ? WDATA : DUMMY;
        DUMMY: if (sclk_rise && dcnt_q == DUMMY_LAST) state_d = RDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_q      <= 1'b0;
      rx_hi_q    <= 4'h0;
      dcnt_q     <= 4'h0;
      is_write_q <= 1'b0;
      wrote_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      rd_buf_q   <= 8'h00;
      tx_lo_q    <= 4'h0;
      sio_out_q  <= 4'h0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      load_q     <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      ren_q  <= 1'b0;
      done_q <= 1'b0;
      load_q <= ren_q;
      oe_q   <= (state_d == RDATA);
      // The RAM has captured the address by the end of a strobe clk, so step to the next byte.
      if (wen_q || ren_q) addr_q <= addr_q + 1'b1;
      if (load_q)         rd_buf_q <= ram.ram_rdata;

      if (cs_rise) begin
        done_q  <= wrote_q;
        wrote_q <= 1'b0;
        nib_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            nib_q     <= 1'b0;
            dcnt_q    <= 4'h0;
            wrote_q   <= 1'b0;
            sio_out_q <= 4'h0;
          end
          CMD, ADDR, WDATA: begin
            if (sclk_rise) begin
              if (!nib_q) rx_hi_q <= sio_s;
              nib_q <= ~nib_q;
            end
            if (byte_done) begin
              if (state_q == CMD) begin
                is_write_q <= (rx_byte == CMD_QWRITE);
              end else if (state_q == ADDR) begin
                addr_q <= addr_width'(rx_byte);
                dcnt_q <= 4'h0;
                if (!is_write_q) ren_q <= 1'b1;
              end else begin
                wen_q   <= 1'b1;
                wdata_q <= rx_byte;
                wrote_q <= 1'b1;
              end
            end
          end
          DUMMY: if (sclk_rise) dcnt_q <= dcnt_q + 1'b1;
          RDATA: begin
            // High nibble goes out first; its low half is parked so rd_buf can take the prefetch.
            if (sclk_fall) begin
              if (!nib_q) begin
                sio_out_q <= rd_buf_q[7:4];
                tx_lo_q   <= rd_buf_q[3:0];
                ren_q     <= 1'b1;
              end else begin
                sio_out_q <= tx_lo_q;
              end
              nib_q <= ~nib_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign ram.ram_wen   = wen_q;
  assign ram.ram_ren   = ren_q;
  assign qspi_sio_out  = sio_out_q;
  assign qspi_sio_oe   = oe_q;
  assign frame_done    = done_q;
  assign fsm_state     = state_q;

endmodule
